execute_stage: RTL
==================

// Module: execute_stage
// PURPOSE
//  Execute stage; consumes the E-side outputs of the decode-to-execute pipeline register.
//  Selects forwarded operands, runs the ALU and resolves branches/jumps.
//  Runs an iterative RV32M multiply/divide unit; BusyE stalls F/D/E while that unit runs.
//  Outputs feed the execute-to-memory register and the fetch PC mux.
// PARAMETERS
//  WIDTH      32  datapath width
//  MD_CYCLES  32  iterations per mul/div operation; must equal WIDTH
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      synchronous active-high reset
//  FlushE         in   1      squash the current E instruction; aborts any mul/div in progress
//  RD1E,RD2E      in   WIDTH  register-file operands
//  PCE,PCPlus4E   in   WIDTH  instruction PC and PC+4
//  ExtImmE        in   WIDTH  sign-extended immediate
//  ALUctrlE       in   4      ALU opcode (pkg alu_op_t)
//  ALUsrcE        in   1      1: operand B = ExtImmE
//  PcSrcE         in   3      pkg pc_src_t: SEQ/JAL/JALR/BRANCH
//  Funct3E        in   3      branch condition / mul-div op select
//  MulDivE        in   1      instruction is RV32M
//  ForwardAE,BE   in   2      00 reg, 01 ResultW, 10 ALUResultM
//  ALUResultM     in   WIDTH  forward source, memory stage
//  ResultW        in   WIDTH  forward source, writeback stage
//  ALUResultE     out  WIDTH  ALU or mul/div result
//  WriteDataE     out  WIDTH  forwarded operand B before the ALUsrc mux (store data)
//  PCTargetE      out  WIDTH  jump/branch target; bit 0 forced to 0 for JALR
//  PCTakenE       out  1      redirect fetch to PCTargetE
//  BusyE          out  1      mul/div in progress; hazard unit holds F/D/E registers
// BEHAVIOUR
//  - Operand A = fwd(RD1E,ForwardAE); B = ALUsrcE ? ExtImmE : fwd(RD2E,ForwardBE). ForwardxE=11 selects the reg value.
//  - ALU is combinational, 0-cycle latency.
//    ADD SUB AND OR XOR; SLL SRL SRA use B[4:0]; SLT SLTU give 0/1; PASSB (LUI).
//    Undefined codes -> 0.
//  - Branch and jump resolution:
//    BRANCH uses Funct3: BEQ BNE BLT BGE BLTU BGEU on fwd A vs fwd B.
//    Target = PCE+ExtImmE. JALR target = (A+ExtImmE)&~1.
//    JAL/JALR: ALUResultE = PCPlus4E, PCTakenE = 1.
//    PCTakenE = 0 when FlushE or BusyE.
//  - Mul/div FSM states IDLE, RUN, DONE. Reset -> IDLE, BusyE=0, counter=0, acc=0.
//    IDLE->RUN when MulDivE && !FlushE: latch fwd A, B, Funct3 and operand signs; BusyE=1 in that cycle.
//    RUN runs MD_CYCLES iterations, BusyE=1 throughout. Multiply is shift-add on |A|,|B|; divide is restoring.
//    RUN->DONE after the last iteration. DONE: BusyE=0, ALUResultE = fixed-up result, then DONE->IDLE.
//  - Latency: issue cycle n; result valid and BusyE=0 in cycle n+MD_CYCLES+1.
//    Back-to-back mul/div restarts from IDLE in the following cycle.
//  - Result fix-up:
//    MUL gives low word. MULH, MULHSU, MULHU give the high word with the correct sign handling.
//    Divide by zero: quotient = all-ones, remainder = dividend.
//    Signed -2^31 / -1: quotient = -2^31, remainder = 0.
//  - FlushE or rst in any state -> IDLE next edge, BusyE=0 next cycle, partial result discarded.
//  - ALUResultE = 0 while BusyE=1.
//  - Upstream obligation: the decode-to-execute register must hold while BusyE=1.
//  - Widths: arithmetic wraps mod 2^WIDTH; the mul/div accumulator is 2*WIDTH wide.
// STRUCTURE
//  - Package riscv_pkg holds alu_op_t (4b enum), pc_src_t (3b enum), branch funct3 and mul/div funct3 localparams.
//  - One sub-module, muldiv_iter: FSM, counter and datapath for the iterative multiply/divide.
//    Its interface is start/op/a/b -> busy/done/result.
//  - ALU, forwarding muxes and branch compare stay inline.
// TESTING
//  - Forwarding add:
//    RD1E=5, ForwardAE=10, ALUResultM=7, ALUsrcE=1, ExtImmE=3, ADD -> ALUResultE=10, PCTakenE=0.
//  - Signed branch:
//    BLT with A=0xFFFFFFFF, B=1, PCE=0x100, ExtImmE=0x20 -> PCTakenE=1, PCTargetE=0x120.
//    Same operands with BLTU -> PCTakenE=0.
//  - JALR: A=0x1003, ExtImmE=0 -> PCTargetE=0x1002, ALUResultE=PCPlus4E.
//  - MULH: A=0x80000000, B=2 -> BusyE high for 33 cycles, then ALUResultE=0xFFFFFFFF.
//    MUL with the same operands -> 0.
//  - Divide corner cases:
//    DIV 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7.
//    DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
//  - Abort mid-operation:
//    FlushE in RUN cycle 10 -> BusyE=0 next cycle, FSM in IDLE.
//    A new DIVU 100/7 then yields 14. The same check is repeated with rst in place of FlushE.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared opcodes, branch and mul/div funct3 codes for the execute stage
package riscv_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_PASSB
  } alu_op_t;
  typedef enum logic [2:0] {PC_SEQ, PC_JAL, PC_JALR, PC_BRANCH} pc_src_t;
  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_t;
  localparam logic [2:0] F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE = 3'd5,
                         F3_BLTU = 3'd6, F3_BGEU = 3'd7;
  localparam logic [2:0] F3_MUL = 3'd0, F3_MULH = 3'd1, F3_MULHSU = 3'd2, F3_MULHU = 3'd3,
                         F3_DIV = 3'd4, F3_DIVU = 3'd5, F3_REM = 3'd6, F3_REMU = 3'd7;
  function automatic logic md_signed_a(input logic [2:0] op);
    return op == F3_MULH || op == F3_MULHSU || op == F3_DIV || op == F3_REM;
  endfunction
  function automatic logic md_signed_b(input logic [2:0] op);
    return op == F3_MULH || op == F3_DIV || op == F3_REM;
  endfunction
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M unit, shift-add multiply and restoring divide on magnitudes
module muldiv_iter
  import riscv_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);
  localparam int CW = $clog2(MD_CYCLES + 1);
  md_state_t            r_state, w_next;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_acc, w_step, w_prod;
  logic [WIDTH-1:0]     r_m, r_a_raw, w_abs_a, w_abs_b, w_q, w_r, w_fix;
  logic [WIDTH:0]       w_sum, w_diff;
  logic [2:0]           r_op;
  logic                 r_sa, r_sb, r_bz, w_sa, w_sb, w_go, w_last;
  always_comb begin
    w_sa    = md_signed_a(i_op) && i_a[WIDTH-1];
    w_sb    = md_signed_b(i_op) && i_b[WIDTH-1];
    w_abs_a = w_sa ? -i_a : i_a;
    w_abs_b = w_sb ? -i_b : i_b;
    w_go    = r_state == MD_IDLE && i_start && !i_flush;
    w_last  = r_cnt == CW'(MD_CYCLES - 1);
    w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_m};
    w_diff  = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_m};
    w_step  = r_op[2] ? (w_diff[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                       : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1})
                      : (r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]});
    w_prod  = (r_sa ^ r_sb) ? -r_acc : r_acc;
    w_q     = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_r     = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    // divide by zero overrides; signed overflow falls out of the magnitude path naturally
    w_fix   = r_op == F3_MUL ? w_prod[WIDTH-1:0]
            : r_op inside {F3_MULH, F3_MULHSU, F3_MULHU} ? w_prod[2*WIDTH-1:WIDTH]
            : r_op inside {F3_DIV, F3_DIVU} ? (r_bz ? '1 : w_q)
            : (r_bz ? r_a_raw : w_r);
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= MD_IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = i_flush ? MD_IDLE
           : r_state == MD_IDLE ? (i_start ? MD_RUN : MD_IDLE)
           : r_state == MD_RUN ? (w_last ? MD_DONE : MD_RUN)
           : MD_IDLE;
  end
  always_comb begin
    o_busy   = w_go || r_state == MD_RUN;
    o_done   = r_state == MD_DONE;
    o_result = r_state == MD_DONE ? w_fix : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_m     <= '0;
      r_a_raw <= '0;
      r_op    <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_bz    <= 1'b0;
    end else if (w_go) begin
      r_cnt   <= '0;
      r_acc   <= {{WIDTH{1'b0}}, i_op[2] ? w_abs_a : w_abs_b};
      r_m     <= i_op[2] ? w_abs_b : w_abs_a;
      r_a_raw <= i_a;
      r_op    <= i_op;
      r_sa    <= w_sa;
      r_sb    <= w_sb;
      r_bz    <= i_b == '0;
    end else if (r_state == MD_RUN && !i_flush) begin
      r_cnt   <= r_cnt + CW'(1);
      r_acc   <= w_step;
    end
  end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: operand forwarding, ALU, branch/jump resolution and iterative mul/div
module execute_stage
  import riscv_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             FlushE,
  input  logic [WIDTH-1:0] RD1E,
  input  logic [WIDTH-1:0] RD2E,
  input  logic [WIDTH-1:0] PCE,
  input  logic [WIDTH-1:0] PCPlus4E,
  input  logic [WIDTH-1:0] ExtImmE,
  input  logic [3:0]       ALUctrlE,
  input  logic             ALUsrcE,
  input  logic [2:0]       PcSrcE,
  input  logic [2:0]       Funct3E,
  input  logic             MulDivE,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic [WIDTH-1:0] ResultW,
  output logic [WIDTH-1:0] ALUResultE,
  output logic [WIDTH-1:0] WriteDataE,
  output logic [WIDTH-1:0] PCTargetE,
  output logic             PCTakenE,
  output logic             BusyE
);
  localparam int SW = $clog2(WIDTH);
  logic [WIDTH-1:0] w_a, w_bf, w_b, w_alu, w_md_res, w_jalr;
  logic             w_cond, w_jump, w_md_done;
  muldiv_iter #(.WIDTH(WIDTH), .MD_CYCLES(MD_CYCLES)) u_md (
    .clk      (clk),
    .rst      (rst),
    .i_flush  (FlushE),
    .i_start  (MulDivE),
    .i_op     (Funct3E),
    .i_a      (w_a),
    .i_b      (w_bf),
    .o_busy   (BusyE),
    .o_done   (w_md_done),
    .o_result (w_md_res)
  );
  always_comb begin
    w_a  = ForwardAE == 2'b01 ? ResultW : ForwardAE == 2'b10 ? ALUResultM : RD1E;
    w_bf = ForwardBE == 2'b01 ? ResultW : ForwardBE == 2'b10 ? ALUResultM : RD2E;
    w_b  = ALUsrcE ? ExtImmE : w_bf;
  end
  always_comb begin
    case (alu_op_t'(ALUctrlE))
      ALU_ADD:   w_alu = w_a + w_b;
      ALU_SUB:   w_alu = w_a - w_b;
      ALU_AND:   w_alu = w_a & w_b;
      ALU_OR:    w_alu = w_a | w_b;
      ALU_XOR:   w_alu = w_a ^ w_b;
      ALU_SLL:   w_alu = w_a << w_b[SW-1:0];
      ALU_SRL:   w_alu = w_a >> w_b[SW-1:0];
      ALU_SRA:   w_alu = WIDTH'($signed(w_a) >>> w_b[SW-1:0]);
      ALU_SLT:   w_alu = {{(WIDTH-1){1'b0}}, $signed(w_a) < $signed(w_b)};
      ALU_SLTU:  w_alu = {{(WIDTH-1){1'b0}}, w_a < w_b};
      ALU_PASSB: w_alu = w_b;
      default:   w_alu = '0;
    endcase
  end
  always_comb begin
    w_cond = Funct3E == F3_BEQ  ? w_a == w_bf
           : Funct3E == F3_BNE  ? w_a != w_bf
           : Funct3E == F3_BLT  ? $signed(w_a) < $signed(w_bf)
           : Funct3E == F3_BGE  ? $signed(w_a) >= $signed(w_bf)
           : Funct3E == F3_BLTU ? w_a < w_bf
           : Funct3E == F3_BGEU ? w_a >= w_bf
           : 1'b0;
    w_jump     = PcSrcE == PC_JAL || PcSrcE == PC_JALR;
    w_jalr     = w_a + ExtImmE;
    PCTargetE  = PcSrcE == PC_JALR ? {w_jalr[WIDTH-1:1], 1'b0} : PCE + ExtImmE;
    PCTakenE   = !FlushE && !BusyE && (w_jump || (PcSrcE == PC_BRANCH && w_cond));
    ALUResultE = BusyE ? '0 : w_md_done ? w_md_res : w_jump ? PCPlus4E : w_alu;
    WriteDataE = w_bf;
  end
endmodule
